game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter: MAX_TRIES, 10, guesses allowed per game (1..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a new game.
REQ-005 digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-006 digit  input  4  player digit; legal values 0..9.
REQ-007 submit  input  1  one-cycle pulse; commit the entered guess.
REQ-008 dp_valid  input  1  datapath: secret generation complete.
REQ-009 dp_input_error  input  1  datapath: the presented guess has duplicate digits.
REQ-010 dp_same  input  1  datapath: guess equals the secret.
REQ-011 Anum, Bnum  input  3 each  datapath score for the loaded guess.
REQ-012 save_test  output  1  request to the datapath to generate the secret.
REQ-013 load_guess  output  1  one-cycle strobe; datapath latches ans0..ans3.
REQ-014 ans0..ans3  output  4 each  guess digits; ans0 is the first digit entered.
REQ-015 digit_cnt  output  3  digits entered in the current guess (0..4).
REQ-016 attempts  output  4  scored guesses in the current game.
REQ-017 last_A, last_B  output  3 each  registered score of the most recent guess.
REQ-018 result_valid  output  1  one-cycle pulse when last_A and last_B update.
REQ-019 err  output  1  one-cycle pulse when a guess is rejected for duplicate digits.
REQ-020 win, lose, busy  output  1 each  game-over flags; busy is high in GEN.

Function
REQ-021 FSM states: IDLE, GEN, ENTRY, CHECK, LOAD, SETTLE, SCORE, WIN, LOSE; encoding is free.
REQ-022 IDLE: on start, go to GEN; clear attempts, digit_cnt, ans0..ans3, last_A, last_B.
REQ-023 GEN: drive save_test high every cycle; on the first cycle with dp_valid=1, go to ENTRY. No timeout.
REQ-024 ENTRY, on digit_valid with digit<=9 and digit_cnt<4: write digit to ans[digit_cnt] and increment digit_cnt.
REQ-025 ENTRY: ignore a digit >9 and any digit while digit_cnt==4; no state change.
REQ-026 ENTRY: ignore submit while digit_cnt<4; submit with digit_cnt==4 goes to CHECK.
REQ-027 ENTRY: if digit_valid and submit arrive in the same cycle, submit takes precedence and the digit is dropped.
REQ-028 CHECK (1 cycle), dp_input_error=1: pulse err, clear digit_cnt, return to ENTRY; attempts unchanged.
REQ-029 CHECK, dp_input_error=0: go to LOAD.
REQ-030 LOAD: assert load_guess for exactly 1 cycle, then go to SETTLE.
REQ-031 SETTLE: wait 1 cycle for the datapath outputs to settle, then go to SCORE.
REQ-032 SCORE: register Anum into last_A and Bnum into last_B, increment attempts, pulse result_valid.
REQ-033 SCORE next state: WIN if dp_same=1 or Anum==4; else LOSE if the incremented attempts==MAX_TRIES; else ENTRY with digit_cnt cleared.
REQ-034 WIN and LOSE hold their flag high and ignore digit_valid and submit; start begins a new game as in REQ-022.
REQ-035 start in ENTRY, CHECK, LOAD, SETTLE or SCORE aborts the current game and behaves as in REQ-022. start in GEN is ignored.
REQ-036 Latency from an accepted submit to result_valid: exactly 4 cycles (CHECK, LOAD, SETTLE, SCORE).
REQ-037 attempts never exceeds MAX_TRIES and never wraps.
REQ-038 ans0..ans3 hold their values outside ENTRY writes.

Reset
REQ-039 On reset assertion, immediately enter IDLE and drive all outputs to 0: save_test, load_guess, ans*, digit_cnt, attempts, last_A, last_B, result_valid, err, win, lose, busy.
REQ-040 Reset mid-game discards all progress; after release, the FSM stays in IDLE until start.

Verification
REQ-041 Win path: start; dp_valid after 3 cycles; digits 1,2,3,4; submit; datapath returns Anum=4, Bnum=0, dp_same=1 -> load_guess pulses once, result_valid 4 cycles after submit, last_A=4, attempts=1, win=1.
REQ-042 Duplicate guess: digits 5,5,6,7; submit with dp_input_error=1 -> err pulses once, no load_guess, attempts=0, digit_cnt=0, FSM in ENTRY.
REQ-043 Lose path, MAX_TRIES=10: ten legal guesses each scored Anum=1, Bnum=2 -> attempts=10, lose=1, win=0; further submits are ignored.
REQ-044 Entry boundaries: digit 12 ignored; 5th digit ignored; submit with 3 digits ignored; digit_valid and submit together with 4 digits -> CHECK, digit dropped.
REQ-045 Abort/reset: start during SETTLE -> GEN with attempts=0; async reset pulse mid-ENTRY -> all outputs 0 with no clock edge, IDLE held until start.

Source files
------------

// File: rtl/game_ctrl.sv
// Bulls-and-cows style game controller: sequences secret generation, digit entry,
// guess validation and scoring against an external datapath.
module game_ctrl #(
  parameter int unsigned MAX_TRIES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       submit,
  input  logic       dp_valid,
  input  logic       dp_input_error,
  input  logic       dp_same,
  input  logic [2:0] Anum,
  input  logic [2:0] Bnum,
  output logic       save_test,
  output logic       load_guess,
  output logic [3:0] ans0,
  output logic [3:0] ans1,
  output logic [3:0] ans2,
  output logic [3:0] ans3,
  output logic [2:0] digit_cnt,
  output logic [3:0] attempts,
  output logic [2:0] last_A,
  output logic [2:0] last_B,
  output logic       result_valid,
  output logic       err,
  output logic       win,
  output logic       lose,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_GEN, S_ENTRY, S_CHECK, S_LOAD, S_SETTLE, S_SCORE, S_WIN, S_LOSE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] ans_r [4];
  logic       new_game, take_digit, clr_cnt, do_score, reject;
  logic [3:0] att_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    new_game   = 1'b0;
    take_digit = 1'b0;
    clr_cnt    = 1'b0;
    do_score   = 1'b0;
    reject     = 1'b0;
    att_inc    = attempts + 4'd1;
    case (state)
      S_GEN:    if (dp_valid) state_nxt = S_ENTRY;
      S_ENTRY: begin
        if (submit && digit_cnt == 3'd4)
          state_nxt = S_CHECK;
        else if (digit_valid && digit <= 4'd9 && digit_cnt < 3'd4)
          take_digit = 1'b1;
      end
      S_CHECK: begin
        if (dp_input_error) begin
          reject    = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = S_ENTRY;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_SCORE;
      S_SCORE: begin
        do_score = 1'b1;
        if (dp_same || Anum == 3'd4) begin
          state_nxt = S_WIN;
        end else if (att_inc == 4'(MAX_TRIES)) begin
          state_nxt = S_LOSE;
        end else begin
          clr_cnt   = 1'b1;
          state_nxt = S_ENTRY;
        end
      end
      default: ;
    endcase
    // start overrides whatever the current state decided, except during generation
    if (start && state != S_GEN) begin
      new_game   = 1'b1;
      take_digit = 1'b0;
      clr_cnt    = 1'b0;
      do_score   = 1'b0;
      reject     = 1'b0;
      state_nxt  = S_GEN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) ans_r[i] <= '0;
      digit_cnt    <= '0;
      attempts     <= '0;
      last_A       <= '0;
      last_B       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= do_score;
      err          <= reject;
      if (new_game) begin
        for (int unsigned i = 0; i < 4; i++) ans_r[i] <= '0;
        digit_cnt <= '0;
        attempts  <= '0;
        last_A    <= '0;
        last_B    <= '0;
      end else begin
        if (take_digit) begin
          ans_r[digit_cnt[1:0]] <= digit;
          digit_cnt             <= digit_cnt + 3'd1;
        end
        if (clr_cnt) digit_cnt <= '0;
        if (do_score) begin
          last_A <= Anum;
          last_B <= Bnum;
          if (attempts < 4'(MAX_TRIES)) attempts <= att_inc;
        end
      end
    end
  end

  assign ans0       = ans_r[0];
  assign ans1       = ans_r[1];
  assign ans2       = ans_r[2];
  assign ans3       = ans_r[3];
  assign save_test  = (state == S_GEN);
  assign busy       = (state == S_GEN);
  assign load_guess = (state == S_LOAD);
  assign win        = (state == S_WIN);
  assign lose       = (state == S_LOSE);

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed game scenarios push expected score/err
// events; a negedge monitor pops and compares them as the DUT reports.
module tb_game_ctrl;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, digit_valid = 1'b0, submit = 1'b0;
  logic       dp_valid = 1'b0, dp_input_error = 1'b0, dp_same = 1'b0;
  logic [3:0] digit = '0;
  logic [2:0] Anum = '0, Bnum = '0;
  logic       save_test, load_guess, result_valid, err, win, lose, busy;
  logic [3:0] ans0, ans1, ans2, ans3, attempts;
  logic [2:0] digit_cnt, last_A, last_B;

  game_ctrl #(.MAX_TRIES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .digit_valid(digit_valid), .digit(digit),
    .submit(submit), .dp_valid(dp_valid), .dp_input_error(dp_input_error),
    .dp_same(dp_same), .Anum(Anum), .Bnum(Bnum), .save_test(save_test),
    .load_guess(load_guess), .ans0(ans0), .ans1(ans1), .ans2(ans2), .ans3(ans3),
    .digit_cnt(digit_cnt), .attempts(attempts), .last_A(last_A), .last_B(last_B),
    .result_valid(result_valid), .err(err), .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, load_cnt = 0;

  typedef struct {
    bit is_err; int cyc; int a; int b; int att; int dcnt; bit w; bit l;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit is_err, input int a, input int b, input int att,
                              input int dcnt, input bit w, input bit l);
    exp_t e;
    e.is_err = is_err; e.cyc = 0; e.a = a; e.b = b; e.att = att;
    e.dcnt = dcnt; e.w = w; e.l = l;
    return e;
  endfunction

  // Monitor: compares each DUT report against the oldest expectation.
  always @(negedge clk) begin
    if (load_guess) load_cnt++;
    if (!reset && (result_valid || err)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: result_valid=%0b err=%0b, expected no output",
                 result_valid, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("kind_err", int'(err), int'(e.is_err));
        chk("kind_result", int'(result_valid), int'(!e.is_err));
        chk("latency_cycle", cyc, e.cyc);
        chk("last_A", int'(last_A), e.a);
        chk("last_B", int'(last_B), e.b);
        chk("attempts", int'(attempts), e.att);
        chk("digit_cnt", int'(digit_cnt), e.dcnt);
        chk("win", int'(win), int'(e.w));
        chk("lose", int'(lose), int'(e.l));
      end
    end
  end

  // Stimulus changes 1 time unit after the falling edge so the monitor has already sampled.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic do_submit(input bit push, input exp_t e);
    exp_t t;
    t = e;
    t.cyc = cyc + (e.is_err ? 2 : 5);
    if (push) q.push_back(t);
    submit = 1'b1;
    step();
    submit = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("pending_expectations", q.size(), 0);
  endtask

  task automatic new_game();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gen_busy", int'(busy), 1);
    chk("gen_save_test", int'(save_test), 1);
    chk("gen_attempts_clear", int'(attempts), 0);
    chk("gen_lastA_clear", int'(last_A), 0);
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    chk("entry_not_busy", int'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_save_test"}, int'(save_test), 0);
    chk({tag, "_load_guess"}, int'(load_guess), 0);
    chk({tag, "_ans0"}, int'(ans0), 0);
    chk({tag, "_ans1"}, int'(ans1), 0);
    chk({tag, "_ans2"}, int'(ans2), 0);
    chk({tag, "_ans3"}, int'(ans3), 0);
    chk({tag, "_digit_cnt"}, int'(digit_cnt), 0);
    chk({tag, "_attempts"}, int'(attempts), 0);
    chk({tag, "_last_A"}, int'(last_A), 0);
    chk({tag, "_last_B"}, int'(last_B), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_win"}, int'(win), 0);
    chk({tag, "_lose"}, int'(lose), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb;
    step();
    check_zero("reset");
    reset = 1'b0;
    step();

    // Win path with a 3-cycle secret generation delay
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("gen_wait_busy", int'(busy), 1);
      step();
    end
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    chk("entry_after_gen", int'(busy), 0);
    Anum = 3'd4; Bnum = 3'd0; dp_same = 1'b1;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("win_ans0", int'(ans0), 1);
    chk("win_ans3", int'(ans3), 4);
    chk("win_cnt", int'(digit_cnt), 4);
    load_cnt = 0;
    do_submit(1'b1, mk(1'b0, 4, 0, 1, 4, 1'b1, 1'b0));
    drain();
    chk("win_load_pulses", load_cnt, 1);
    press(4'd7);
    do_submit(1'b0, mk(1'b0, 0, 0, 0, 0, 1'b0, 1'b0));
    repeat (6) step();
    chk("win_hold", int'(win), 1);
    chk("win_ans0_hold", int'(ans0), 1);
    chk("win_attempts_hold", int'(attempts), 1);

    // Duplicate-digit guess rejected
    new_game();
    chk("new_ans0_clear", int'(ans0), 0);
    dp_same = 1'b0; dp_input_error = 1'b1;
    press(4'd5); press(4'd5); press(4'd6); press(4'd7);
    load_cnt = 0;
    do_submit(1'b1, mk(1'b1, 0, 0, 0, 0, 1'b0, 1'b0));
    drain();
    step();
    chk("dup_no_load", load_cnt, 0);
    chk("dup_err_one_pulse", int'(err), 0);
    dp_input_error = 1'b0;
    press(4'd3);
    chk("dup_back_in_entry", int'(digit_cnt), 1);
    chk("dup_new_ans0", int'(ans0), 3);

    // Entry boundaries
    press(4'd12);
    chk("digit12_ignored", int'(digit_cnt), 1);
    press(4'd8); press(4'd9);
    do_submit(1'b0, mk(1'b0, 0, 0, 0, 0, 1'b0, 1'b0));
    repeat (6) step();
    chk("submit3_cnt", int'(digit_cnt), 3);
    chk("submit3_no_load", load_cnt, 0);
    press(4'd0);
    press(4'd6);
    chk("fifth_digit_cnt", int'(digit_cnt), 4);
    chk("fifth_digit_ans3", int'(ans3), 0);
    Anum = 3'd1; Bnum = 3'd2;
    digit = 4'd7;
    digit_valid = 1'b1;
    do_submit(1'b1, mk(1'b0, 1, 2, 1, 0, 1'b0, 1'b0));
    digit_valid = 1'b0;
    drain();
    chk("combo_ans0", int'(ans0), 3);
    chk("combo_ans1", int'(ans1), 8);
    chk("combo_ans2", int'(ans2), 9);
    chk("combo_ans3", int'(ans3), 0);

    // Lose path: nine more scored guesses
    for (int g = 2; g <= 10; g++) begin
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      do_submit(1'b1, mk(1'b0, 1, 2, g, (g == 10) ? 4 : 0, 1'b0, g == 10));
      drain();
    end
    chk("lose_flag", int'(lose), 1);
    chk("lose_win", int'(win), 0);
    chk("lose_attempts", int'(attempts), 10);
    do_submit(1'b0, mk(1'b0, 0, 0, 0, 0, 1'b0, 1'b0));
    repeat (6) step();
    chk("lose_attempts_hold", int'(attempts), 10);
    chk("lose_hold", int'(lose), 1);

    // Abort during SETTLE
    new_game();
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    do_submit(1'b1, mk(1'b0, 1, 2, 1, 0, 1'b0, 1'b0));
    drain();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    lb = load_cnt;
    do_submit(1'b0, mk(1'b0, 0, 0, 0, 0, 1'b0, 1'b0));
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_busy", int'(busy), 1);
    chk("abort_attempts", int'(attempts), 0);
    chk("abort_last_A", int'(last_A), 0);
    chk("abort_cnt", int'(digit_cnt), 0);
    chk("abort_load_seen", load_cnt, lb + 1);
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    repeat (6) step();

    // Asynchronous reset mid-entry
    press(4'd1); press(4'd2);
    chk("pre_reset_cnt", int'(digit_cnt), 2);
    #1 reset = 1'b1;
    #1 check_zero("async_reset");
    reset = 1'b0;
    repeat (5) step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_save_test", int'(save_test), 0);
    chk("idle_cnt", int'(digit_cnt), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", int'(busy), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
